booth_serial_mult_ctrl: RTL and testbench
=========================================

Name: booth_serial_mult_ctrl

Overview:
- Sequential controller that multiplies a signed WA-bit multiplicand A by a signed WB-bit multiplier B.
- B is recoded into radix-2 Booth digits {-1, 0, +1}, one digit per cycle.
- Each digit drives a small signed digit-multiplier cell (A times digit), and the shifted partial product is accumulated.
- The block sits between a requesting unit (start/done handshake) and the digit-multiply datapath, and owns sequencing, shifting and accumulation.

Parameters:
- WA, 3, width of signed multiplicand A.
- WB, 4, width of signed multiplier B; also the number of RUN cycles.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  request to begin a multiply; sampled on rising edge.
- A  input  WA  signed multiplicand; captured when start is accepted.
- B  input  WB  signed multiplier; captured when start is accepted.
- busy  output  1  high while a multiply is in progress.
- done  output  1  single-cycle pulse when prod becomes valid.
- prod  output  WA+WB  signed product; held stable from done until the next accepted start.

Behaviour:
- Reset: one clock, synchronous, active-high. On reset: state=IDLE, busy=0, done=0, prod=0, accumulator=0, digit counter=0. Reset mid-operation aborts the operation; the result is discarded.
- States: IDLE, RUN, DONE.
- IDLE: busy=0.
  - start=1 -> latch A and B, clear accumulator, counter=0, go to RUN.
  - start=0 -> stay in IDLE.
- RUN: busy=1; one Booth digit processed per cycle; counter runs 0..WB-1.
  - Digit i is d = b[i-1] - b[i], with b[-1]=0.
  - Encoding to the cell: 2'b00=0, 2'b01=+1, 2'b11=-1. The pair (b[i], b[i-1]) = 01 -> +1, 10 -> -1, 00/11 -> 0.
  - The cell product d*A is formed with A sign-extended to WA+WB bits before negation, so A = -2^(WA-1) negates without overflow.
  - acc <= acc + ((d*A) << i), computed modulo 2^(WA+WB). The final result is exact for all input pairs.
  - When counter = WB-1: write acc+term to prod and go to DONE.
  - start is ignored while in RUN; A and B changes are ignored after capture.
- DONE: done=1 for exactly this one cycle; busy=0.
  - prod is valid here and remains held afterwards.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back) -> RUN.
  - Otherwise -> IDLE.
- Latency: start accepted at edge k -> RUN on cycles k+1..k+WB -> done=1 in cycle k+WB+1.
  - With defaults: done follows start by 5 cycles.
  - Throughput: one result per WB+1 cycles.
- prod changes only on the RUN->DONE transition or on reset; it is never updated mid-RUN.
- busy and done are never high in the same cycle.
- No X propagation: unused digit encoding 2'b10 is never generated.

Test Plan:
- Reset, then A=3, B=-8, start for 1 cycle -> busy high 4 cycles, done pulse 5 cycles after start, prod=7'b1101000 (-24).
- A=-4, B=-8 (both most negative) -> prod=7'b0100000 (+32); covers -A sign-extension.
- A=-4, B=7 -> prod=-28 (7'b1100100). Hold start high through DONE and assert new inputs A=2, B=-3 at done -> second op accepted with no idle gap, prod=-6 five cycles later.
- A=0, B=5, then A=3, B=0 -> prod=0 both times; done still pulses at the fixed 5-cycle latency.
- Pulse start again during RUN with different A/B -> ignored; result matches the original operands; busy not extended.
- Assert rst during RUN cycle 2 -> next cycle busy=0, done=0, prod=0, state IDLE. A subsequent start with A=1, B=1 gives prod=1.
- Exhaustive sweep of all 8x16 A/B pairs against a reference signed multiply.

Source files
------------

// File: rtl/booth_serial_mult_ctrl.sv
// Radix-2 Booth serial multiplier: one recoded digit of B per cycle, with the
// partial product accumulated into a WA+WB-bit result behind a start/done handshake.

module booth_digit_cell #(
  parameter int W = 7
) (
  input  logic [1:0]   enc,
  input  logic [W-1:0] mcand,
  output logic [W-1:0] term
);
  // enc: 00 -> 0, 01 -> +1, 11 -> -1 (10 is never produced)
  always_comb begin
    term = '0;
    case (enc)
      2'b01:   term = mcand;
      2'b11:   term = -mcand;
      default: term = '0;
    endcase
  end
endmodule

module booth_serial_mult_ctrl #(
  parameter int WA = 3,
  parameter int WB = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WA-1:0]    A,
  input  logic [WB-1:0]    B,
  output logic             busy,
  output logic             done,
  output logic [WA+WB-1:0] prod
);
  localparam int P  = WA + WB;
  localparam int CW = (WB > 1) ? $clog2(WB) : 1;
  localparam logic [CW-1:0] LAST = CW'(WB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [P-1:0]  a_sh, acc, term, sum, a_ext;
  logic [WB-1:0] b_sh;
  logic          b_prev;
  logic [CW-1:0] cnt;
  logic [1:0]    enc;

  // A is sign-extended to full width first so that negating the most
  // negative multiplicand cannot overflow.
  assign a_ext = {{WB{A[WA-1]}}, A};

  // Pair (b[i], b[i-1]): 01 -> +1, 10 -> -1, 00/11 -> 0
  assign enc = {b_sh[0] & ~b_prev, b_sh[0] ^ b_prev};

  booth_digit_cell #(.W(P)) u_cell (
    .enc   (enc),
    .mcand (a_sh),
    .term  (term)
  );

  assign sum = acc + term;

  // a_sh carries A << i and b_sh exposes b[i] at bit 0, so no barrel shifter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      prod   <= '0;
      acc    <= '0;
      cnt    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      b_prev <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh   <= a_ext;
            b_sh   <= B;
            b_prev <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        RUN: begin
          acc    <= sum;
          a_sh   <= a_sh << 1;
          b_prev <= b_sh[0];
          b_sh   <= b_sh >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            prod  <= sum;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_booth_serial_mult_ctrl.sv
// Directed and randomized checks of the Booth serial multiplier against plain signed arithmetic.

module tb_booth_serial_mult_ctrl;
  localparam int WA = 3;
  localparam int WB = 4;
  localparam int P  = WA + WB;
  localparam int LAT = WB + 1;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [WA-1:0] A;
  logic [WB-1:0] B;
  logic         busy, done;
  logic [P-1:0] prod;

  int n_chk  = 0;
  int n_fail = 0;

  booth_serial_mult_ctrl #(.WA(WA), .WB(WB)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .prod  (prod)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sval(input int v, input int w);
    return (v >= (1 << (w - 1))) ? v - (1 << w) : v;
  endfunction

  // Reference: exact signed product reduced to P bits
  function automatic longint ref_prod(input int a, input int b);
    return longint'(sval(a, WA) * sval(b, WB)) & ((longint'(1) << P) - 1);
  endfunction

  // Launch one op, then follow it to done; checks latency, busy span and result.
  task automatic run_op(input int a, input int b, input string tag, input bit full);
    int lat, bc, both;
    A = WA'(a); B = WB'(b); start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1; bc = 0; both = 0;
    while (!done && lat < 4 * LAT) begin
      if (busy) bc++;
      tick();
      lat++;
    end
    if (busy && done) both = 1;
    chk({tag, "_lat"}, lat, LAT);
    chk({tag, "_prod"}, prod, ref_prod(a, b));
    if (full) begin
      chk({tag, "_busycnt"}, bc, WB);
      chk({tag, "_busy_done_excl"}, both, 0);
      tick();
      chk({tag, "_done_pulse"}, done, 0);
      chk({tag, "_prod_hold"}, prod, ref_prod(a, b));
    end else begin
      tick();
    end
  endtask

  initial begin
    int lat;
    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_prod", prod, 0);

    run_op(3, 8, "t_3x-8", 1'b1);
    run_op(4, 8, "t_-4x-8", 1'b1);
    run_op(0, 5, "t_0x5", 1'b1);
    run_op(3, 0, "t_3x0", 1'b1);

    // Back-to-back: start held through DONE with new operands
    A = 3'd4; B = 4'd7; start = 1'b1;
    tick();
    lat = 1;
    while (!done && lat < 4 * LAT) begin tick(); lat++; end
    chk("b2b_lat1", lat, LAT);
    chk("b2b_prod1", prod, ref_prod(4, 7));
    A = 3'd2; B = 4'd13;
    tick();
    start = 1'b0;
    chk("b2b_busy_nogap", busy, 1);
    chk("b2b_prod_held_midrun", prod, ref_prod(4, 7));
    lat = 1;
    while (!done && lat < 4 * LAT) begin tick(); lat++; end
    chk("b2b_lat2", lat, LAT);
    chk("b2b_prod2", prod, ref_prod(2, 13));
    tick();

    // start pulsed during RUN with other operands must be ignored
    A = 3'd3; B = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    A = 3'd6; B = 4'd9; start = 1'b1;
    tick();
    start = 1'b0; A = 3'd1; B = 4'd1;
    lat = 3;
    while (!done && lat < 4 * LAT) begin tick(); lat++; end
    chk("ign_lat", lat, LAT);
    chk("ign_prod", prod, ref_prod(3, 5));
    tick();
    chk("ign_no_extend", busy, 0);

    // Reset in RUN cycle 2 aborts the op
    A = 3'd3; B = 4'd7; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_prod", prod, 0);
    tick(); tick();
    chk("midrst_stay_idle", busy, 0);
    run_op(1, 1, "t_after_rst", 1'b1);

    for (int a = 0; a < (1 << WA); a++)
      for (int b = 0; b < (1 << WB); b++)
        run_op(a, b, $sformatf("sweep_%0d_%0d", sval(a, WA), sval(b, WB)), 1'b0);

    for (int k = 0; k < 40; k++)
      run_op(int'($urandom_range((1 << WA) - 1)), int'($urandom_range((1 << WB) - 1)),
             $sformatf("rnd%0d", k), 1'b1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
